lane_reorder_ctrl: RTL and testbench

Controller that builds and supervises the physical-to-logical PCS lane map for 100GbE receive deskew/reorder. Each per-physical-lane alignment-marker aligner reports a one-hot match mask, which identifies the logical lane it matched, plus a valid pulse. This block decodes the masks, detects duplicate or illegal IDs, and declares the map locked once every logical lane is claimed. While locked it re-checks every marker and drops lock after repeated mismatches. It sits between the aligner bank and the reorder mux, and drives that mux's select table.

---
 rtl/pcs_lane_pkg.sv | 18 +
 rtl/onehot_id_decode.sv | 19 +
 rtl/lane_reorder_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lane_reorder_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pcs_lane_pkg.sv
// Shared definitions for the PCS lane reorder controller: lane count, ID width,
// FSM state type and the flattened-slice index helper.
package pcs_lane_pkg;

  localparam int unsigned N_LANES = 20;
  localparam int unsigned ID_LEN  = $clog2(N_LANES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    LOCKED
  } lane_state_e;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/onehot_id_decode.sv
// One-hot match mask to binary lane ID, with a legality flag (exactly one bit set).
module onehot_id_decode #(
  parameter int unsigned N_LANES = 20,
  parameter int unsigned ID_LEN  = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] mask,
  output logic [ID_LEN-1:0]  id,
  output logic               legal
);

  always_comb begin
    id = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (mask[i]) id = id | ID_LEN'(i);
    end
    legal = (mask != '0) && ((mask & (mask - N_LANES'(1))) == '0);
  end

endmodule

// File: rtl/lane_reorder_ctrl.sv
// Builds and supervises the physical-to-logical PCS lane map for 100GbE RX reorder.
// Optional LANE_REORDER_STATS_EN adds o_relock_count (saturating relock counter).
module lane_reorder_ctrl
  import pcs_lane_pkg::*;
#(
  parameter int unsigned N_LANES      = pcs_lane_pkg::N_LANES,
  parameter int unsigned ID_LEN       = $clog2(N_LANES),
  parameter int unsigned TIMEOUT_CYC  = 65536,
  parameter int unsigned MAX_MISMATCH = 3
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [N_LANES-1:0]          i_am_valid,
  input  logic [N_LANES*N_LANES-1:0]  i_match_mask,
  output logic [N_LANES*ID_LEN-1:0]   o_lane_map,
  output logic                        o_map_valid,
  output logic                        o_conflict,
  output logic                        o_bad_mask,
  output logic                        o_timeout,
  output logic                        o_lock_lost
`ifdef LANE_REORDER_STATS_EN
  ,
  output logic [15:0]                 o_relock_count
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned MW = $clog2(MAX_MISMATCH + 1);
  localparam logic [TW-1:0] TIMEOUT_TOP = TW'(TIMEOUT_CYC - 1);
  localparam logic [MW-1:0] MM_MAX      = MW'(MAX_MISMATCH);

  logic [N_LANES-1:0][ID_LEN-1:0] dec_id;
  logic [N_LANES-1:0]             dec_legal;

  for (genvar p = 0; p < N_LANES; p++) begin : g_dec
    onehot_id_decode #(.N_LANES(N_LANES), .ID_LEN(ID_LEN)) u_dec (
      .mask  (i_match_mask[slice_lo(p, N_LANES) +: N_LANES]),
      .id    (dec_id[p]),
      .legal (dec_legal[p])
    );
  end

  lane_state_e                    state_q, state_d;
  logic [N_LANES-1:0][ID_LEN-1:0] map_q, map_d;
  logic [N_LANES-1:0]             rec_q, rec_d;
  logic [N_LANES-1:0]             claimed_q, claimed_d;
  logic [N_LANES-1:0]             acc;
  logic [TW-1:0]                  tcnt_q, tcnt_d;
  logic [N_LANES-1:0][MW-1:0]     mcnt_q, mcnt_d;
  logic                           conflict_d, timeout_d, lost_d, bad_d, clear;

  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    rec_d      = rec_q;
    claimed_d  = claimed_q;
    tcnt_d     = tcnt_q;
    mcnt_d     = mcnt_q;
    acc        = '0;
    conflict_d = 1'b0;
    timeout_d  = 1'b0;
    lost_d     = 1'b0;
    bad_d      = 1'b0;
    clear      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = COLLECT;
          clear   = 1'b1;
        end
      end
      COLLECT: begin
        bad_d = |(i_am_valid & ~dec_legal);
        // acc catches same-cycle duplicates that claimed_q cannot see yet
        for (int unsigned p = 0; p < N_LANES; p++) begin
          if (i_am_valid[p] && dec_legal[p]) begin
            if (rec_q[p]) begin
              if (map_q[p] != dec_id[p]) conflict_d = 1'b1;
            end else if (claimed_q[dec_id[p]] || acc[dec_id[p]]) begin
              conflict_d = 1'b1;
            end else begin
              acc[dec_id[p]] = 1'b1;
              map_d[p]       = dec_id[p];
              rec_d[p]       = 1'b1;
            end
          end
        end
        claimed_d = claimed_q | acc;
        tcnt_d    = tcnt_q + TW'(1);
        if (conflict_d) begin
          clear = 1'b1;
        end else if (tcnt_q == TIMEOUT_TOP) begin
          timeout_d = 1'b1;
          clear     = 1'b1;
        end else if (&claimed_d) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        bad_d = |(i_am_valid & ~dec_legal);
        for (int unsigned p = 0; p < N_LANES; p++) begin
          if (i_am_valid[p]) begin
            if (dec_legal[p] && dec_id[p] == map_q[p]) mcnt_d[p] = '0;
            else if (mcnt_q[p] != MM_MAX)               mcnt_d[p] = mcnt_q[p] + MW'(1);
            if (mcnt_d[p] == MM_MAX) lost_d = 1'b1;
          end
        end
        if (lost_d) begin
          state_d = COLLECT;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_enable) begin
      state_d    = IDLE;
      clear      = 1'b1;
      conflict_d = 1'b0;
      timeout_d  = 1'b0;
      lost_d     = 1'b0;
      bad_d      = 1'b0;
    end
    if (clear) begin
      map_d     = '0;
      rec_d     = '0;
      claimed_d = '0;
      tcnt_d    = '0;
      mcnt_d    = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      map_q       <= '0;
      rec_q       <= '0;
      claimed_q   <= '0;
      tcnt_q      <= '0;
      mcnt_q      <= '0;
      o_conflict  <= 1'b0;
      o_bad_mask  <= 1'b0;
      o_timeout   <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      rec_q       <= rec_d;
      claimed_q   <= claimed_d;
      tcnt_q      <= tcnt_d;
      mcnt_q      <= mcnt_d;
      o_conflict  <= conflict_d;
      o_bad_mask  <= bad_d;
      o_timeout   <= timeout_d;
      o_lock_lost <= lost_d;
    end
  end

  assign o_lane_map  = map_q;
  assign o_map_valid = (state_q == LOCKED);

`ifdef LANE_REORDER_STATS_EN
  logic locked_once;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      locked_once    <= 1'b0;
      o_relock_count <= '0;
    end else if (state_q != LOCKED && state_d == LOCKED) begin
      if (locked_once && o_relock_count != '1) o_relock_count <= o_relock_count + 16'd1;
      locked_once <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// Directed self-checking bench for lane_reorder_ctrl (TIMEOUT_CYC=64, MAX_MISMATCH=3).
module tb_lane_reorder_ctrl;

  localparam int unsigned NL = 20;
  localparam int unsigned IL = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NL-1:0]   am_valid;
  logic [NL*NL-1:0] match_mask;
  logic [NL*IL-1:0] lane_map;
  logic            map_valid, conflict, bad_mask, timeout, lock_lost;
`ifdef LANE_REORDER_STATS_EN
  logic [15:0]     relock_count;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [NL-1:0][IL-1:0] exp_full;

  always #5 clk = ~clk;

  lane_reorder_ctrl #(
    .N_LANES      (NL),
    .ID_LEN       (IL),
    .TIMEOUT_CYC  (64),
    .MAX_MISMATCH (3)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_am_valid   (am_valid),
    .i_match_mask (match_mask),
    .o_lane_map   (lane_map),
    .o_map_valid  (map_valid),
    .o_conflict   (conflict),
    .o_bad_mask   (bad_mask),
    .o_timeout    (timeout),
    .o_lock_lost  (lock_lost)
`ifdef LANE_REORDER_STATS_EN
    ,
    .o_relock_count (relock_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int unsigned p, input logic [NL-1:0] m);
    am_valid[p] = 1'b1;
    match_mask[p*NL +: NL] = m;
  endtask

  task automatic clear_inputs();
    am_valid   = '0;
    match_mask = '0;
  endtask

  task automatic report(input int unsigned p, input int unsigned id);
    logic [NL-1:0] m;
    m = NL'(1) << id;
    set_lane(p, m);
    step();
    clear_inputs();
  endtask

  // Lanes 0..19 report logical id 19-p, one per cycle
  task automatic lock_pass();
    for (int unsigned p = 0; p < NL; p++) report(p, NL - 1 - p);
  endtask

  initial begin
    for (int p = 0; p < NL; p++) exp_full[p] = IL'(NL - 1 - p);
    rst = 1'b1;
    en  = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    check("rst_map_valid", map_valid, 0);
    check("rst_lane_map", lane_map, 0);
    check("rst_pulses", {conflict, bad_mask, timeout, lock_lost}, 0);

    // Lock
    en = 1'b1;
    step();
    for (int unsigned p = 0; p < NL - 1; p++) report(p, NL - 1 - p);
    check("lock_not_early", map_valid, 0);
    report(NL - 1, 0);
    check("lock_valid", map_valid, 1);
    check("lock_map", lane_map, exp_full);
    check("lock_no_conflict", conflict, 0);

    // Lock loss: two mismatches then a match keep lock; three mismatches drop it
    report(4, 3);
    report(4, 3);
    report(4, 15);
    check("mm2_keep_lock", map_valid, 1);
    check("mm2_no_lost", lock_lost, 0);
    report(4, 3);
    report(4, 3);
    check("mm_before_third", lock_lost, 0);
    report(4, 3);
    check("lost_pulse", lock_lost, 1);
    check("lost_map_valid", map_valid, 0);
    check("lost_map_cleared", lane_map, 0);
    step();
    check("lost_pulse_end", lock_lost, 0);

    // Re-report of the same id is harmless; a different id from a recorded lane conflicts
    report(0, 19);
    report(0, 19);
    check("rereport_same_ok", conflict, 0);
    report(0, 7);
    check("rereport_diff_conflict", conflict, 1);
    check("rereport_diff_cleared", lane_map, 0);

    // Duplicate in one cycle
    report(0, 19);
    set_lane(3, NL'(1) << 5);
    set_lane(7, NL'(1) << 5);
    step();
    clear_inputs();
    check("dup_conflict", conflict, 1);
    check("dup_cleared", lane_map, 0);
    check("dup_no_lock", map_valid, 0);
    step();
    check("dup_pulse_end", conflict, 0);
    lock_pass();
    check("dup_then_lock", map_valid, 1);
    check("dup_then_map", lane_map, exp_full);
`ifdef LANE_REORDER_STATS_EN
    check("relock_count_1", relock_count, 1);
`endif

    // Enable drop while locked
    en = 1'b0;
    step();
    check("dis_map_valid", map_valid, 0);
    check("dis_map", lane_map, 0);
    en = 1'b1;
    step();

    // Bad mask
    set_lane(2, 20'h00003);
    step();
    clear_inputs();
    check("bad_pulse", bad_mask, 1);
    check("bad_no_record", lane_map, 0);
    step();
    check("bad_pulse_end", bad_mask, 0);
    lock_pass();
    check("bad_then_lock", map_valid, 1);

    // Timeout: 19 lanes only; COLLECT entered on the edge after enable
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int unsigned p = 0; p < NL - 1; p++) report(p, NL - 1 - p);
    for (int i = 0; i < 44; i++) step();
    check("to_not_early", timeout, 0);
    check("to_partial_map", lane_map, exp_full);
    check("to_no_lock", map_valid, 0);
    step();
    check("to_pulse", timeout, 1);
    check("to_cleared", lane_map, 0);
    check("to_no_valid", map_valid, 0);
    step();
    check("to_pulse_end", timeout, 0);

    // Reset while locked
    lock_pass();
    check("pre_rst_lock", map_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_lock_valid", map_valid, 0);
    check("rst_lock_map", lane_map, 0);
`ifdef LANE_REORDER_STATS_EN
    check("rst_relock_count", relock_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
